// File: rtl/processor_control_unit_if.sv
// processor_control_unit_if: step qualifier, instruction word and datapath control bundle
// between the control unit (master) and the datapath/debug logic (slave).
interface processor_control_unit_if #(
    parameter int DADDR_W = 8,
    parameter int RADDR_W = 4
);
    logic               step_en;
    logic [15:0]        IR;
    logic               PC_clr;
    logic               PC_up;
    logic               IR_ld;
    logic [DADDR_W-1:0] D_addr;
    logic               D_wr;
    logic               RF_s;
    logic [RADDR_W-1:0] RF_W_addr;
    logic               RF_W_en;
    logic [RADDR_W-1:0] RF_Ra_addr;
    logic [RADDR_W-1:0] RF_Rb_addr;
    logic [2:0]         ALU_s0;
    logic [3:0]         state;
    logic [3:0]         nextState;

    modport master (
        input  step_en, IR,
        output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, state, nextState
    );

    modport slave (
        output step_en, IR,
        input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, state, nextState
    );
endinterface

// File: rtl/processor_control_unit.sv
// processor_control_unit: Moore fetch/decode/execute sequencer for the 16-bit datapath,
// advancing one state per step_en-qualified clock; strobes are gated by step_en.
module processor_control_unit #(
    parameter int DADDR_W = 8,
    parameter int RADDR_W = 4
) (
    input logic                       Clk,
    input logic                       Reset,
    processor_control_unit_if.master  bus
);
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op;
    logic       en, ld, alu;

    assign op = bus.IR[15:12];
    assign en = bus.step_en;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   if (en) state_d = S_FETCH;
            S_FETCH:  if (en) state_d = S_DECODE;
            S_DECODE: if (en) state_d = op == 4'h1 ? S_STORE :
                                        op == 4'h2 ? S_LOADA :
                                        op == 4'h3 ? S_ADD   :
                                        op == 4'h4 ? S_SUB   :
                                        op == 4'h5 ? S_HALT  : S_NOOP;
            S_LOADA:  if (en) state_d = S_LOADB;
            S_LOADB, S_NOOP, S_STORE, S_ADD, S_SUB: if (en) state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            // Unreachable encodings recover without waiting for a step
            default:  state_d = S_INIT;
        endcase
    end

    assign ld  = state_q == S_LOADA || state_q == S_LOADB;
    assign alu = state_q == S_ADD || state_q == S_SUB;

    always_comb begin
        bus.PC_clr     = en & (state_q == S_INIT);
        bus.PC_up      = en & (state_q == S_FETCH);
        bus.IR_ld      = en & (state_q == S_FETCH);
        bus.D_wr       = en & (state_q == S_STORE);
        bus.RF_W_en    = en & (state_q == S_LOADB || alu);
        bus.RF_s       = ld;
        bus.D_addr     = ld ? DADDR_W'(bus.IR[11:4]) :
                         state_q == S_STORE ? DADDR_W'(bus.IR[7:0]) : '0;
        bus.RF_W_addr  = (ld || alu) ? RADDR_W'(bus.IR[3:0]) : '0;
        bus.RF_Ra_addr = (alu || state_q == S_STORE) ? RADDR_W'(bus.IR[11:8]) : '0;
        bus.RF_Rb_addr = alu ? RADDR_W'(bus.IR[7:4]) : '0;
        bus.ALU_s0     = state_q == S_ADD ? 3'b001 : state_q == S_SUB ? 3'b010 : 3'b000;
        bus.state      = state_q;
        bus.nextState  = state_d;
    end
endmodule

// File: tb/tb_processor_control_unit.sv
// tb_processor_control_unit: directed per-scenario checks of the control unit state
// sequence and output decode, including async reset, halt and step_en hold.
module tb_processor_control_unit;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   tests = 0;
    int   failed = 0;

    processor_control_unit_if #(.DADDR_W(8), .RADDR_W(4)) bus ();

    processor_control_unit #(.DADDR_W(8), .RADDR_W(4)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.master)
    );

    always #5 Clk = ~Clk;

    // {state, PC_clr, PC_up, IR_ld, D_wr, RF_W_en, RF_s, ALU_s0, D_addr, RF_W_addr, Ra, Rb}
    logic [32:0] obs;
    assign obs = {bus.state, bus.PC_clr, bus.PC_up, bus.IR_ld, bus.D_wr, bus.RF_W_en,
                  bus.RF_s, bus.ALU_s0, bus.D_addr, bus.RF_W_addr, bus.RF_Ra_addr, bus.RF_Rb_addr};

    function automatic logic [32:0] ev(input logic [3:0] st, input logic [4:0] sb, input logic rs,
                                       input logic [2:0] alu, input logic [7:0] da,
                                       input logic [3:0] wa, input logic [3:0] ra, input logic [3:0] rb);
        return {st, sb, rs, alu, da, wa, ra, rb};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic go_init();
        bus.step_en = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [32:0] e;
        bus.step_en = 1'b0;
        bus.IR = 16'h0000;
        go_init();
        e = ev(4'd0, 5'b00000, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
        tests++; if (obs !== e) begin failed++; $display("FAIL reset_idle got %h want %h", obs, e); end
        bus.IR = 16'h3125;
        bus.step_en = 1'b1;
        tick(); tick();
        #3 Reset = 1'b1;
        #1;
        e = ev(4'd0, 5'b10000, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
        tests++; if (obs !== e) begin failed++; $display("FAIL reset_async got %h want %h", obs, e); end
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        e = ev(4'd1, 5'b01100, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
        tests++; if (obs !== e) begin failed++; $display("FAIL reset_fetch got %h want %h", obs, e); end
    endtask

    task automatic test_add();
        logic [32:0] e;
        go_init();
        bus.IR = 16'h3125;
        bus.step_en = 1'b1;
        tick(); tick();
        tests++; if (bus.nextState !== 4'd7) begin failed++; $display("FAIL add_next got %0d want 7", bus.nextState); end
        tick();
        e = ev(4'd7, 5'b00001, 1'b0, 3'b001, 8'h00, 4'h5, 4'h1, 4'h2);
        tests++; if (obs !== e) begin failed++; $display("FAIL add_exec got %h want %h", obs, e); end
        tick();
        tests++; if (bus.state !== 4'd1) begin failed++; $display("FAIL add_ret got %0d want 1", bus.state); end
    endtask

    task automatic test_load();
        logic [32:0] e;
        go_init();
        bus.IR = 16'h20A7;
        bus.step_en = 1'b1;
        tick(); tick(); tick();
        e = ev(4'd4, 5'b00000, 1'b1, 3'b000, 8'h0A, 4'h7, 4'h0, 4'h0);
        tests++; if (obs !== e) begin failed++; $display("FAIL load_a got %h want %h", obs, e); end
        tick();
        e = ev(4'd5, 5'b00001, 1'b1, 3'b000, 8'h0A, 4'h7, 4'h0, 4'h0);
        tests++; if (obs !== e) begin failed++; $display("FAIL load_b got %h want %h", obs, e); end
        tick();
        tests++; if (bus.state !== 4'd1) begin failed++; $display("FAIL load_ret got %0d want 1", bus.state); end
    endtask

    task automatic test_store_sub();
        logic [32:0] e;
        go_init();
        bus.IR = 16'h13F0;
        bus.step_en = 1'b1;
        tick(); tick(); tick();
        e = ev(4'd6, 5'b00010, 1'b0, 3'b000, 8'hF0, 4'h0, 4'h3, 4'h0);
        tests++; if (obs !== e) begin failed++; $display("FAIL store got %h want %h", obs, e); end
        bus.IR = 16'h4456;
        tick(); tick(); tick();
        e = ev(4'd8, 5'b00001, 1'b0, 3'b010, 8'h00, 4'h6, 4'h4, 4'h5);
        tests++; if (obs !== e) begin failed++; $display("FAIL sub got %h want %h", obs, e); end
    endtask

    task automatic test_halt();
        logic [32:0] e;
        int bad = 0;
        go_init();
        bus.IR = 16'h5000;
        bus.step_en = 1'b1;
        tick(); tick(); tick();
        e = ev(4'd9, 5'b00000, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
        tests++; if (obs !== e) begin failed++; $display("FAIL halt_enter got %h want %h", obs, e); end
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++; if (obs !== e) begin failed++; bad++; $display("FAIL halt_stay%0d got %h want %h", i, obs, e); end
        end
        #2 Reset = 1'b1;
        #1;
        e = ev(4'd0, 5'b10000, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
        tests++; if (obs !== e) begin failed++; $display("FAIL halt_reset got %h want %h", obs, e); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_hold();
        logic [32:0] e;
        go_init();
        bus.IR = 16'h3125;
        bus.step_en = 1'b1;
        tick(); tick(); tick();
        bus.step_en = 1'b0;
        #1;
        e = ev(4'd7, 5'b00000, 1'b0, 3'b001, 8'h00, 4'h5, 4'h1, 4'h2);
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (obs !== e || bus.nextState !== 4'd7) begin
                failed++; $display("FAIL hold%0d got %h/%0d want %h/7", i, obs, bus.nextState, e);
            end
        end
        bus.step_en = 1'b1;
        #1;
        tests++; if (bus.RF_W_en !== 1'b1) begin failed++; $display("FAIL hold_release got %b want 1", bus.RF_W_en); end
        bus.IR = 16'hE123;
        tick(); tick(); tick();
        e = ev(4'd3, 5'b00000, 1'b0, 3'b000, 8'h00, 4'h0, 4'h0, 4'h0);
        tests++; if (obs !== e) begin failed++; $display("FAIL noop_e got %h want %h", obs, e); end
        tick();
        tests++; if (bus.state !== 4'd1) begin failed++; $display("FAIL noop_ret got %0d want 1", bus.state); end
    endtask

    initial begin
        bus.step_en = 1'b0;
        bus.IR = 16'h0000;
        test_reset();
        test_add();
        test_load();
        test_store_sub();
        test_halt();
        test_hold();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
